display_arbiter: RTL and testbench
==================================

Name: display_arbiter

Overview:
Time-shares the single 4-digit seven-segment display driver between NREQ requesters (e.g. CPU status, accelerator result, debug counters). Round-robin scheduling with a programmable dwell time per owner, plus an urgent override for immediate preemption. Outputs feed the display driver's value/point inputs directly. A blank flag tells top-level logic to force all digits off when no requester is active.

Parameters:
NREQ, 4, number of requesters; fixed range 2..8
DWELL, 50000000, cycles an owner is held before rotation is considered; must be >= 2
CNT_W, 26, dwell counter width; must satisfy 2^CNT_W > DWELL
IDX_W, 2, owner index width; must satisfy 2^IDX_W >= NREQ

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
req  in  NREQ  per-requester display request, level-sensitive
urgent  in  NREQ  per-requester preempt request; ignored unless matching req bit is also 1
req_value  in  16*NREQ  flattened values; requester i uses bits [16i+15:16i]
req_point  in  4*NREQ  flattened radix points; requester i uses bits [4i+3:4i]
grant  out  NREQ  one-hot current owner; all zero when idle
owner  out  IDX_W  index of current owner; 0 when idle
disp_value  out  16  value to display driver
disp_point  out  4  radix points to display driver
disp_blank  out  1  1 when no owner
switch_pulse  out  1  single-cycle pulse on the cycle after ownership changes

Behaviour:
- All outputs registered. Reset (reset==0 at clock edge) forces: state=IDLE, grant=0, owner=0, disp_value=0, disp_point=0, disp_blank=1, switch_pulse=0, dwell counter=0. Reset mid-SHOW drops ownership the same edge. No partial state survives.
- Effective request eff_req = req; effective urgent eff_urg = urgent & req.
- States: IDLE, SHOW, URGENT.
- IDLE: if any eff_urg, go to URGENT with the lowest-index urgent requester. Otherwise, if any eff_req, go to SHOW with the first active requester searching round-robin from last_owner+1 (last_owner resets to NREQ-1, so the first grant after reset goes to the lowest active index). Otherwise stay.
- SHOW: dwell counter increments every cycle.
  - Owner's req drops: next cycle pick the next active requester round-robin from owner+1, or IDLE if none.
  - Counter reaches DWELL-1: pick the next active requester round-robin from owner+1, excluding the owner. If one exists, switch and clear the counter. If none, keep the owner and clear the counter (no switch_pulse).
  - Any eff_urg bit, including the owner's: go to URGENT with the lowest-index urgent requester. Urgent has precedence over dwell expiry and over req drop in the same cycle.
- URGENT: no dwell rotation.
  - Owner's urgent drops but its req stays: go to SHOW with the same owner and the counter cleared (no switch_pulse).
  - Owner's req drops: re-evaluate as from IDLE.
  - A lower-index eff_urg appears: switch to it; higher-index urgents wait.
- Ownership change is any change of owner or IDLE<->owned. switch_pulse=1 for exactly one cycle, coincident with the first cycle new grant/disp_* are visible.
- Data path:
  - Each cycle, disp_value/disp_point register the current owner's req_value/req_point slice.
  - Latency is 1 cycle from a requester's value change to disp_value.
  - Latency is 1 cycle from the arbitration decision edge to grant/owner/disp_*.
  - In IDLE, disp_value=0, disp_point=0, disp_blank=1.
- Invariants: grant is one-hot or zero; grant[owner]==1 whenever disp_blank==0; the counter never exceeds DWELL-1.
- Round-robin index wraps NREQ-1 -> 0. last_owner updates on every grant.

Test Plan:
- DWELL=8. Reset low 3 cycles, then high, with req=0 -> grant=0, disp_blank=1, disp_value=0000 held for 20 cycles.
- DWELL=8, req=4'b1011, values 0x1111/0x2222/-/0x4444 -> owner sequence 0,1,3,0 with each owner held exactly 8 cycles; switch_pulse high for 1 cycle at each change.
- DWELL=8, only req[2]=1 -> grant=4'b0100 continuously; switch_pulse never asserts after the first grant.
- Owner 1 in SHOW, req[1] dropped at cycle 3 of dwell with req[3]=1 -> grant=4'b1000 one cycle later; counter restarts.
- Owner 0 in SHOW, urgent[2]&req[2] asserted -> grant=4'b0100 next cycle; holds beyond 3×DWELL. Then urgent[2] drops with req[2] held -> SHOW with owner 2 for 8 cycles, then rotation to the next active requester.
- Owner 3 with req_value 0xBEEF, req_point 4'b0010 -> disp_value=0xBEEF, disp_point=0010 one cycle after. Drive reset low mid-dwell -> next edge shows disp_blank=1 and grant=0.

Source files
------------

// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : display_arbiter
// Function : Round-robin / urgent-preempt time sharing of one 4-digit display.
// Revision : 1.0
// ============================================================================
module display_arbiter #(
  parameter int NREQ  = 4,
  parameter int DWELL = 50000000,
  parameter int CNT_W = 26,
  parameter int IDX_W = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      urgent,
  input  logic [16*NREQ-1:0]   req_value,
  input  logic [4*NREQ-1:0]    req_point,
  output logic [NREQ-1:0]      grant,
  output logic [IDX_W-1:0]     owner,
  output logic [15:0]          disp_value,
  output logic [3:0]           disp_point,
  output logic                 disp_blank,
  output logic                 switch_pulse
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHOW   = 2'd1,
    S_URGENT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [15:0]        value_q, value_d;
  logic [3:0]         point_q, point_d;
  logic               blank_q, blank_d;
  logic               pulse_q, pulse_d;

  logic [NREQ-1:0]    eff_urg;
  logic [IDX_W:0]     urg_pick, rr_all, rr_excl;

  // Returns {found, index}: first set bit of mask scanning base+1, base+2, ... with wrap.
  function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] mask,
                                             input logic [IDX_W-1:0] base);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = IDX_W'((int'(base) + i) % NREQ);
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [IDX_W:0] low_pick(input logic [NREQ-1:0] mask);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (mask[IDX_W'(i)]) res = {1'b1, IDX_W'(i)};
    end
    return res;
  endfunction

  // last_q equals owner_q whenever a requester is owned, so it serves as the rotation base.
  assign eff_urg  = urgent & req;
  assign urg_pick = low_pick(eff_urg);
  assign rr_all   = rr_pick(req, last_q);
  assign rr_excl  = rr_pick(req & ~grant_q, last_q);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = '0;
    if (state_q == S_IDLE || !req[owner_q] || (state_q == S_SHOW && |eff_urg)) begin
      if (urg_pick[IDX_W]) begin
        state_d = S_URGENT;
        owner_d = urg_pick[IDX_W-1:0];
      end else if (rr_all[IDX_W]) begin
        state_d = S_SHOW;
        owner_d = rr_all[IDX_W-1:0];
      end else begin
        state_d = S_IDLE;
        owner_d = '0;
      end
    end else if (state_q == S_URGENT) begin
      if (urg_pick[IDX_W]) begin
        owner_d = urg_pick[IDX_W-1:0];
      end else begin
        state_d = S_SHOW;
      end
    end else if (cnt_q == CNT_W'(DWELL - 1)) begin
      if (rr_excl[IDX_W]) owner_d = rr_excl[IDX_W-1:0];
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Display path follows the next owner so data and grant appear on the same cycle.
  always_comb begin
    grant_d = '0;
    value_d = '0;
    point_d = '0;
    blank_d = 1'b1;
    if (state_d != S_IDLE) begin
      grant_d = NREQ'(1) << owner_d;
      blank_d = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (owner_d == IDX_W'(i)) begin
          value_d = req_value[16*i +: 16];
          point_d = req_point[4*i +: 4];
        end
      end
    end
    pulse_d = ((state_d != S_IDLE) != (state_q != S_IDLE)) ||
              ((state_d != S_IDLE) && (state_q != S_IDLE) && (owner_d != owner_q));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NREQ - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      value_q <= '0;
      point_q <= '0;
      blank_q <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (state_d != S_IDLE) last_q <= owner_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      value_q <= value_d;
      point_q <= point_d;
      blank_q <= blank_d;
      pulse_q <= pulse_d;
    end
  end

  assign grant        = grant_q;
  assign owner        = owner_q;
  assign disp_value   = value_q;
  assign disp_point   = point_q;
  assign disp_blank   = blank_q;
  assign switch_pulse = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_arbiter
// Function : Scoreboard bench for display_arbiter with a short dwell time.
// Revision : 1.0
// ============================================================================
module tb_display_arbiter;
  localparam int NREQ  = 4;
  localparam int DWELL = 8;
  localparam int CNT_W = 4;
  localparam int IDX_W = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   urgent = '0;
  logic [15:0]       vals [NREQ];
  logic [3:0]        pts  [NREQ];
  logic [16*NREQ-1:0] req_value;
  logic [4*NREQ-1:0]  req_point;
  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  owner;
  logic [15:0]       disp_value;
  logic [3:0]        disp_point;
  logic              disp_blank;
  logic              switch_pulse;

  typedef struct packed {
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic [15:0] value;
    logic [3:0]  point;
    logic        blank;
    logic        pulse;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_n    = 0;

  assign req_value = {vals[3], vals[2], vals[1], vals[0]};
  assign req_point = {pts[3], pts[2], pts[1], pts[0]};

  always #5 clock = ~clock;

  display_arbiter #(
    .NREQ (NREQ),
    .DWELL(DWELL),
    .CNT_W(CNT_W),
    .IDX_W(IDX_W)
  ) u_dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .urgent      (urgent),
    .req_value   (req_value),
    .req_point   (req_point),
    .grant       (grant),
    .owner       (owner),
    .disp_value  (disp_value),
    .disp_point  (disp_point),
    .disp_blank  (disp_blank),
    .switch_pulse(switch_pulse)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc_n, got, exp);
    end
  endtask

  // Expectation for the next edge is pushed with the current inputs, then popped and compared.
  task automatic expect_cycle(input bit idle, input int own, input bit pulse);
    exp_t e;
    e.grant = idle ? 4'b0000 : 4'(1 << own);
    e.owner = idle ? 2'd0 : 2'(own);
    e.value = idle ? 16'h0000 : vals[own];
    e.point = idle ? 4'h0 : pts[own];
    e.blank = idle;
    e.pulse = pulse;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    cyc_n++;
    e = sb_q.pop_front();
    check_eq("grant", 32'(grant), 32'(e.grant));
    check_eq("owner", 32'(owner), 32'(e.owner));
    check_eq("disp_value", 32'(disp_value), 32'(e.value));
    check_eq("disp_point", 32'(disp_point), 32'(e.point));
    check_eq("disp_blank", 32'(disp_blank), 32'(e.blank));
    check_eq("switch_pulse", 32'(switch_pulse), 32'(e.pulse));
  endtask

  task automatic reset_dut();
    reset  = 1'b0;
    req    = '0;
    urgent = '0;
    expect_cycle(1'b1, 0, 1'b0);
    expect_cycle(1'b1, 0, 1'b0);
    reset  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=running exp=finished", cyc_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq [4];
    vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    pts  = '{4'h1, 4'h2, 4'h4, 4'h8};

    // Reset held, then released with nobody requesting.
    for (int i = 0; i < 3; i++) expect_cycle(1'b1, 0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) expect_cycle(1'b1, 0, 1'b0);

    // Round-robin over requesters 0,1,3 with full dwell each.
    reset_dut();
    req = 4'b1011;
    seq = '{0, 1, 3, 0};
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < DWELL; k++) expect_cycle(1'b0, seq[s], k == 0);

    // Lone requester keeps the display across dwell expiries without pulses.
    reset_dut();
    req = 4'b0100;
    expect_cycle(1'b0, 2, 1'b1);
    for (int k = 0; k < 3 * DWELL; k++) expect_cycle(1'b0, 2, 1'b0);

    // Owner drops request mid-dwell; successor gets a fresh full dwell.
    reset_dut();
    req = 4'b1010;
    expect_cycle(1'b0, 1, 1'b1);
    expect_cycle(1'b0, 1, 1'b0);
    expect_cycle(1'b0, 1, 1'b0);
    req = 4'b1001;
    expect_cycle(1'b0, 3, 1'b1);
    for (int k = 1; k < DWELL; k++) expect_cycle(1'b0, 3, 1'b0);
    expect_cycle(1'b0, 0, 1'b1);

    // Urgent preemption, long hold, then fall back to normal dwell and rotation.
    reset_dut();
    req = 4'b0101;
    expect_cycle(1'b0, 0, 1'b1);
    expect_cycle(1'b0, 0, 1'b0);
    urgent = 4'b0100;
    expect_cycle(1'b0, 2, 1'b1);
    for (int k = 0; k < 3 * DWELL + 1; k++) expect_cycle(1'b0, 2, 1'b0);
    urgent = 4'b0000;
    for (int k = 0; k < DWELL; k++) expect_cycle(1'b0, 2, 1'b0);
    expect_cycle(1'b0, 0, 1'b1);
    urgent = 4'b0010;
    expect_cycle(1'b0, 0, 1'b0);
    urgent = 4'b0000;

    // Data path latency and reset while showing.
    reset_dut();
    vals[3] = 16'hBEEF;
    pts[3]  = 4'b0010;
    req = 4'b1000;
    expect_cycle(1'b0, 3, 1'b1);
    expect_cycle(1'b0, 3, 1'b0);
    expect_cycle(1'b0, 3, 1'b0);
    vals[3] = 16'h1234;
    expect_cycle(1'b0, 3, 1'b0);
    reset = 1'b0;
    expect_cycle(1'b1, 0, 1'b0);
    reset = 1'b1;
    req = '0;
    expect_cycle(1'b1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
